// File: rtl/elevator_pkg.sv
// elevator_pkg: shared door-state encoding and dwell-counter width for the car controllers.
//   door_state_e : CLOSED=0, OPENING=1, OPEN=2, CLOSING=3
//   CNT_W / cnt_t: 8-bit tick counter used by every timed state
package elevator_pkg;

    localparam int CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } door_state_e;

endpackage

// File: rtl/tick_sync.sv
// tick_sync: brings a slow divider square wave into the clk domain and emits a 1-cycle tick per rising edge.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   level_in : asynchronous square wave (1 Hz / 4 Hz / 8 Hz divider output)
//   tick     : one-cycle strobe, 3 clocks after level_in rises
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic tick
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       tick_q, tick_d;

    always_comb begin
        sync_d = {sync_q[0], level_in};
        prev_d = sync_q[1];
        tick_d = sync_q[1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/door_sequencer.sv
// door_sequencer: elevator door open/dwell/close sequencer timed by a 1 Hz divider tick.
//   frequency_50Mhz   : system clock
//   reset_n           : asynchronous active-low reset
//   frequency_1hz     : 1 Hz square wave, sampled as data
//   at_floor          : car level with a landing; opening only allowed when high
//   open_req          : level request to open / hold open
//   obstruction       : doorway sensor; forces reopen / hold
//   motor_open        : drive door toward open (OPENING only)
//   motor_close       : drive door toward closed (CLOSING only)
//   door_locked       : door closed, car free to move (CLOSED only)
//   door_closed_pulse : one-cycle strobe when a close stroke completes
//   state             : current state code
module door_sequencer
    import elevator_pkg::*;
#(
    parameter int OPEN_TIME_S = 5,
    parameter int MOVE_TIME_S = 2
) (
    input  logic       frequency_50Mhz,
    input  logic       reset_n,
    input  logic       frequency_1hz,
    input  logic       at_floor,
    input  logic       open_req,
    input  logic       obstruction,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_locked,
    output logic       door_closed_pulse,
    output logic [1:0] state
);

    localparam cnt_t OPEN_CNT = cnt_t'(OPEN_TIME_S);
    localparam cnt_t MOVE_CNT = cnt_t'(MOVE_TIME_S);

    door_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        tick;
    logic        hold;
    logic        last;
    cnt_t        cnt_dec;
    cnt_t        back_cnt;

    tick_sync u_tick_sync (
        .clk      (frequency_50Mhz),
        .rst_n    (reset_n),
        .level_in (frequency_1hz),
        .tick     (tick)
    );

    assign hold    = open_req | obstruction;
    assign last    = cnt_q == cnt_t'(1);
    assign cnt_dec = cnt_q - cnt_t'(1);
    // A reversal mid-close only has to travel back the distance already closed.
    assign back_cnt = MOVE_CNT - cnt_q;

    always_ff @(posedge frequency_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLOSED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Hold/reversal requests are tested before the tick so they win a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLOSED: begin
                if (at_floor && hold) begin
                    state_d = ST_OPENING;
                    cnt_d   = MOVE_CNT;
                end
            end
            ST_OPENING: begin
                if (tick) begin
                    state_d = last ? ST_OPEN : ST_OPENING;
                    cnt_d   = last ? OPEN_CNT : cnt_dec;
                end
            end
            ST_OPEN: begin
                if (hold) begin
                    cnt_d = OPEN_CNT;
                end else if (tick) begin
                    state_d = last ? ST_CLOSING : ST_OPEN;
                    cnt_d   = last ? MOVE_CNT : cnt_dec;
                end
            end
            ST_CLOSING: begin
                if (hold) begin
                    state_d = (back_cnt == '0) ? ST_OPEN : ST_OPENING;
                    cnt_d   = (back_cnt == '0) ? OPEN_CNT : back_cnt;
                end else if (tick) begin
                    state_d = last ? ST_CLOSED : ST_CLOSING;
                    cnt_d   = last ? '0 : cnt_dec;
                end
            end
        endcase
    end

    always_comb begin
        pulse_d           = (state_q == ST_CLOSING) && (state_d == ST_CLOSED);
        motor_open        = state_q == ST_OPENING;
        motor_close       = state_q == ST_CLOSING;
        door_locked       = state_q == ST_CLOSED;
        door_closed_pulse = pulse_q;
        state             = state_q;
    end

endmodule

// File: tb/tb_door_sequencer.sv
// tb_door_sequencer: table-driven + scoreboard bench for door_sequencer (OPEN=5, MOVE=2, 1 Hz = 20 clocks).
module tb_door_sequencer;

    localparam logic [1:0] CL = 2'd0, OG = 2'd1, OP = 2'd2, CG = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       freq = 1'b0;
    logic       at_floor = 1'b0;
    logic       open_req = 1'b0;
    logic       obstruction = 1'b0;
    logic       motor_open, motor_close, door_locked, door_closed_pulse;
    logic [1:0] state;
    logic [4:0] obs_vec;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic pulse_prev = 1'b0;
    logic wide_seen = 1'b0;
    logic both_seen = 1'b0;

    typedef struct {
        string      tag;
        logic       af;
        logic       orq;
        logic       obs;
        logic [1:0] early;
        logic [1:0] late;
    } row_t;

    row_t tbl[$];
    row_t sb_q[$];

    door_sequencer #(.OPEN_TIME_S(5), .MOVE_TIME_S(2)) dut (
        .frequency_50Mhz   (clk),
        .reset_n           (reset_n),
        .frequency_1hz     (freq),
        .at_floor          (at_floor),
        .open_req          (open_req),
        .obstruction       (obstruction),
        .motor_open        (motor_open),
        .motor_close       (motor_close),
        .door_locked       (door_locked),
        .door_closed_pulse (door_closed_pulse),
        .state             (state)
    );

    assign obs_vec = {state, door_locked, motor_open, motor_close};

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (10) @(negedge clk);
            freq = ~freq;
        end
    end

    always @(negedge clk) begin
        if (door_closed_pulse) pulses <= pulses + 1;
        if (door_closed_pulse && pulse_prev) wide_seen <= 1'b1;
        pulse_prev <= door_closed_pulse;
        if (motor_open && motor_close) both_seen <= 1'b1;
        if (reset_n) begin
            motor_excl: assert (!(motor_open && motor_close))
                else $error("FAIL motor_excl: motor_open=1 motor_close=1, want never both");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    function automatic logic [4:0] vec(input logic [1:0] s);
        return {s, s == CL, s == OG, s == CG};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d locked=%0b mo=%0b mc=%0b, want state=%0d locked=%0b mo=%0b mc=%0b",
                     name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic add(input string t, input logic af, input logic orq, input logic obs,
                       input logic [1:0] e, input logic [1:0] l, input int n = 1);
        row_t r;
        r.tag = t; r.af = af; r.orq = orq; r.obs = obs; r.early = e; r.late = l;
        repeat (n) tbl.push_back(r);
    endtask

    // One row spans one 1 Hz period: drive just after freq falls, check 2 clocks later
    // (before the tick) and again at the next fall (after the tick).
    task automatic step(input row_t r);
        row_t e;
        at_floor    = r.af;
        open_req    = r.orq;
        obstruction = r.obs;
        sb_q.push_back(r);
        repeat (2) @(negedge clk);
        check({r.tag, "_early"}, obs_vec, vec(sb_q[0].early));
        @(negedge freq);
        e = sb_q.pop_front();
        check({e.tag, "_late"}, obs_vec, vec(e.late));
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset", obs_vec, vec(CL));
        check_int("reset_pulse", int'(door_closed_pulse), 0);
        reset_n = 1'b1;
        @(negedge freq);

        add("normal", 1, 1, 0, OG, OG);
        add("normal", 1, 0, 0, OG, OP);
        add("normal", 1, 0, 0, OP, OP, 4);
        add("normal", 1, 0, 0, OP, CG);
        add("normal", 1, 0, 0, CG, CG);
        add("normal", 1, 0, 0, CG, CL);
        run_table();
        check_int("normal_pulses", pulses, 1);

        add("interlock", 0, 1, 0, CL, CL, 10);
        run_table();

        add("hold", 1, 1, 0, OG, OG);
        add("hold", 1, 0, 0, OG, OP);
        add("hold", 1, 0, 1, OP, OP, 12);
        add("hold", 1, 0, 0, OP, OP, 4);
        add("hold", 1, 0, 0, OP, CG);
        add("hold", 1, 0, 0, CG, CG);
        add("rev_cnt1", 1, 0, 1, OG, OP);
        add("rev_cnt1", 1, 0, 0, OP, OP, 4);
        add("rev_cnt1", 1, 0, 0, OP, CG);
        add("rev_cnt2", 1, 0, 1, OP, OP);
        add("rev_cnt2", 1, 0, 0, OP, OP, 4);
        add("rev_cnt2", 1, 0, 0, OP, CG);
        add("rev_cnt2", 1, 0, 0, CG, CG);
        add("rev_cnt2", 1, 0, 0, CG, CL);
        run_table();
        check_int("hold_rev_pulses", pulses, 2);

        add("sim_open", 1, 1, 0, OG, OG);
        add("sim_open", 1, 0, 0, OG, OP);
        add("sim_open", 1, 0, 0, OP, OP, 4);
        run_table();
        // OPEN with cnt=1: raise open_req for exactly the cycle in which the tick is consumed.
        @(posedge freq);
        repeat (3) @(negedge clk);
        open_req = 1'b1;
        @(negedge clk);
        open_req = 1'b0;
        check("sim_hold", obs_vec, vec(OP));
        @(negedge freq);
        check("sim_hold_late", obs_vec, vec(OP));
        add("sim_tail_nofloor", 0, 0, 0, OP, OP, 4);
        add("sim_tail_nofloor", 0, 0, 0, OP, CG);
        add("sim_tail_nofloor", 0, 0, 0, CG, CG);
        add("sim_tail_nofloor", 0, 0, 0, CG, CL);
        run_table();
        check_int("sim_pulses", pulses, 3);

        add("rst_open", 1, 1, 0, OG, OG);
        add("rst_open", 1, 0, 0, OG, OP);
        add("rst_open", 1, 0, 0, OP, OP);
        run_table();
        #2 reset_n = 1'b0;
        #1;
        check("rst_async", obs_vec, vec(CL));
        check_int("rst_async_pulse", int'(door_closed_pulse), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge freq);
        check("rst_after", obs_vec, vec(CL));
        check_int("rst_pulses", pulses, 3);

        check_int("pulse_width", int'(wide_seen), 0);
        check_int("motor_excl_seen", int'(both_seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/door_sequencer.md
DOOR_SEQUENCER -- requirements
Module: door_sequencer

Interface
REQ-001 Parameter OPEN_TIME_S, default 5, number of 1 Hz ticks the door SHALL dwell fully open (legal 1..255).
REQ-002 Parameter MOVE_TIME_S, default 2, number of 1 Hz ticks a full open or close stroke SHALL take (legal 1..255).
REQ-003 Port frequency_50Mhz, input, 1, sole system clock; all flops SHALL be clocked on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port frequency_1hz, input, 1, 1 Hz square wave from the clock divider, used only as data, never as a clock.
REQ-006 Port at_floor, input, 1, car is level with a landing; opening is permitted only when high.
REQ-007 Port open_req, input, 1, level request to open or hold the door open.
REQ-008 Port obstruction, input, 1, doorway sensor; high forces reopen or hold.
REQ-009 Port motor_open, output, 1, drive door toward open.
REQ-010 Port motor_close, output, 1, drive door toward closed.
REQ-011 Port door_locked, output, 1, door closed and car free to move.
REQ-012 Port door_closed_pulse, output, 1, one-cycle strobe when a close stroke completes.
REQ-013 Port state, output, 2, current state code: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3.

Function
REQ-014 frequency_1hz SHALL pass through a 2-flop synchronizer followed by a rising-edge detector producing a 1-cycle internal tick; latency is 3 clocks from the input edge to tick.
REQ-015 An 8-bit down-counter cnt SHALL hold the ticks remaining in the current timed state.
REQ-016 CLOSED: if at_floor=1 and (open_req|obstruction)=1, go to OPENING with cnt=MOVE_TIME_S; otherwise hold. Ticks are ignored.
REQ-017 OPENING: on tick, if cnt==1 go to OPEN with cnt=OPEN_TIME_S, else cnt decrements.
REQ-018 OPEN: if open_req|obstruction, cnt reloads OPEN_TIME_S (this takes priority over a coincident tick); else on tick, if cnt==1 go to CLOSING with cnt=MOVE_TIME_S, else cnt decrements.
REQ-019 CLOSING: open_req|obstruction reverses to OPENING with cnt=MOVE_TIME_S-cnt. If that value is 0, go directly to OPEN with cnt=OPEN_TIME_S. Reversal takes priority over a coincident tick.
REQ-020 CLOSING with no reversal: on tick, if cnt==1 go to CLOSED, cnt=0, and assert door_closed_pulse for exactly one cycle; else cnt decrements.
REQ-021 at_floor falling while not CLOSED SHALL NOT alter sequencing; the door always completes to CLOSED under its own timing.
REQ-022 Outputs are registered and decoded from the state register: motor_open=1 only in OPENING, motor_close=1 only in CLOSING, door_locked=1 only in CLOSED. motor_open and motor_close SHALL never both be 1.
REQ-023 State transitions occur on the clock edge after the qualifying condition; outputs reflect the new state in that same cycle.

Reset
REQ-024 reset_n low SHALL immediately force state=CLOSED, cnt=0, synchronizer and edge flops=0, motor_open=0, motor_close=0, door_locked=1, door_closed_pulse=0.
REQ-025 Reset asserted mid-stroke SHALL abandon the stroke with no pulse. After release, operation resumes from CLOSED. One spurious tick within 3 clocks of release (if frequency_1hz is high) is permitted and harmless in CLOSED.

Structure
REQ-026 The state encoding constants and the counter width (8) SHALL live in a shared elevator package used by the future car-motion controller.
REQ-027 The synchronizer plus edge detector SHALL be a separate sub-module, tick_sync, reusable for the 4 Hz and 8 Hz divider outputs.
REQ-028 The state/counter logic SHALL be a single registered process with a separate combinational next-state decode.

Verification (OPEN_TIME_S=5, MOVE_TIME_S=2; frequency_1hz driven as a fast square wave, period 20 clocks)
REQ-029 Normal cycle: at_floor=1, pulse open_req for 1 clock -> OPENING for 2 ticks, OPEN for 5 ticks, CLOSING for 2 ticks, then CLOSED with a single door_closed_pulse; 9 ticks total.
REQ-030 Hold open: keep obstruction=1 for 12 ticks while OPEN -> state stays OPEN; CLOSING starts exactly 5 ticks after obstruction falls.
REQ-031 Reversal: assert obstruction 1 tick into CLOSING (cnt=1) -> OPENING with cnt=1, then OPEN after 1 tick. Assert it before the first CLOSING tick (cnt=2) -> directly OPEN.
REQ-032 Interlock: at_floor=0 with open_req=1 for 10 ticks -> state stays CLOSED, door_locked=1, both motors 0.
REQ-033 Reset mid-OPEN: drive reset_n low asynchronously -> door_locked=1 and state=0 with no clock edge; no door_closed_pulse is issued.
REQ-034 Simultaneous events: open_req and tick in the same cycle while OPEN with cnt=1 -> cnt=5, no transition. A bench assertion confirms the motors are never both high.
